// File: rtl/fifo_break_dv_if.sv
// fifo_break_dv_if
// Handshake bundle for the elastic FIFO. Both sides share one interface.
// The upstream side carries ins/ins_valid/ins_ready and the downstream side
// carries outs/outs_valid/outs_ready.
//   master : environment view (drives ins, ins_valid, outs_ready)
//   slave  : FIFO view (drives ins_ready, outs, outs_valid)
interface fifo_break_dv_if #(
    parameter int DATA_TYPE = 32
);
    logic [DATA_TYPE-1:0] ins;
    logic                 ins_valid;
    logic                 ins_ready;
    logic [DATA_TYPE-1:0] outs;
    logic                 outs_valid;
    logic                 outs_ready;

    modport master (
        output ins,
        output ins_valid,
        input  ins_ready,
        input  outs,
        input  outs_valid,
        output outs_ready
    );

    modport slave (
        input  ins,
        input  ins_valid,
        output ins_ready,
        output outs,
        output outs_valid,
        input  outs_ready
    );
endinterface

// File: rtl/fifo_break_dv.sv
// fifo_break_dv
// Elastic circular-buffer FIFO placed after a floating-point unit. It absorbs
// results while the consumer stalls and cuts the combinational valid/data
// paths. All outputs depend only on stored state (ins_ready also on rst).
// There is no input-to-output bypass, so the minimum latency is one cycle.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : handshake bundle (slave view). It carries ins/ins_valid/ins_ready
//         on the upstream side and outs/outs_valid/outs_ready on the
//         downstream side.
module fifo_break_dv #(
    parameter int DATA_TYPE = 32,
    parameter int NUM_SLOTS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_break_dv_if.slave       bus
);

    localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_SLOTS - 1);

    logic [DATA_TYPE-1:0] mem_r [NUM_SLOTS];
    logic [PTR_W-1:0]     head_r;
    logic [PTR_W-1:0]     tail_r;
    logic                 full_r;

    logic                 empty_s;
    logic                 push_s;
    logic                 pop_s;
    logic [PTR_W-1:0]     head_next_s;
    logic [PTR_W-1:0]     tail_next_s;
    logic                 full_next_s;

    // Pointer increment with wrap; NUM_SLOTS need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == LAST_PTR) begin
            r = {PTR_W{1'b0}};
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    // Handshake events, next pointers and next full flag.
    always_comb begin
        empty_s     = (head_r == tail_r) && !full_r;
        push_s      = bus.ins_valid && !full_r && rst;
        pop_s       = !empty_s && bus.outs_ready;
        head_next_s = ptr_inc(head_r);
        tail_next_s = ptr_inc(tail_r);
        full_next_s = full_r;
        if (push_s && !pop_s) begin
            // Only a net gain of one word can make the FIFO full.
            if (tail_next_s == head_r) begin
                full_next_s = 1'b1;
            end else begin
                full_next_s = full_r;
            end
        end else if (pop_s && !push_s) begin
            full_next_s = 1'b0;
        end else begin
            full_next_s = full_r;
        end
    end

    // Control state: pointers and full flag, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_r <= {PTR_W{1'b0}};
            tail_r <= {PTR_W{1'b0}};
            full_r <= 1'b0;
        end else begin
            if (push_s) begin
                tail_r <= tail_next_s;
            end
            if (pop_s) begin
                head_r <= head_next_s;
            end
            full_r <= full_next_s;
        end
    end

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[tail_r] <= bus.ins;
        end
    end

    // Outputs are driven straight from stored state (no path from ins/outs_ready).
    assign bus.outs       = mem_r[head_r];
    assign bus.outs_valid = !empty_s;
    assign bus.ins_ready  = !full_r && rst;

endmodule

// File: tb/tb_fifo_break_dv.sv
// tb_fifo_break_dv
// Self-checking bench for fifo_break_dv. Three instances (4, 3 and 1 slots)
// share clk/rst; one is exercised at a time against a queue-based model.
`timescale 1ns/1ps
module tb_fifo_break_dv;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_break_dv_if #(.DATA_TYPE(32)) if4 ();
    fifo_break_dv_if #(.DATA_TYPE(32)) if3 ();
    fifo_break_dv_if #(.DATA_TYPE(32)) if1 ();

    fifo_break_dv #(.DATA_TYPE(32), .NUM_SLOTS(4)) u4 (.clk(clk), .rst(rst), .bus(if4));
    fifo_break_dv #(.DATA_TYPE(32), .NUM_SLOTS(3)) u3 (.clk(clk), .rst(rst), .bus(if3));
    fifo_break_dv #(.DATA_TYPE(32), .NUM_SLOTS(1)) u1 (.clk(clk), .rst(rst), .bus(if1));

    int checks   = 0;
    int failures = 0;

    int          cur = 0;     // 0: 4-slot, 1: 3-slot, 2: 1-slot
    int          cap = 4;
    logic [31:0] q[$];        // model contents, q[0] is the head
    int          npop = 0;
    logic        last_push = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One cycle: drive inputs, check outputs vs model, advance model at the edge.
    task automatic step(input logic v, input logic [31:0] d, input logic r, input logic rs);
        logic [31:0] o;
        logic        ov;
        logic        ir;
        logic        exp_ov;
        logic        exp_ir;
        logic        pop;
        rst = rs;
        case (cur)
            1: begin if3.ins_valid = v; if3.ins = d; if3.outs_ready = r; end
            2: begin if1.ins_valid = v; if1.ins = d; if1.outs_ready = r; end
            default: begin if4.ins_valid = v; if4.ins = d; if4.outs_ready = r; end
        endcase
        #1;
        case (cur)
            1: begin o = if3.outs; ov = if3.outs_valid; ir = if3.ins_ready; end
            2: begin o = if1.outs; ov = if1.outs_valid; ir = if1.ins_ready; end
            default: begin o = if4.outs; ov = if4.outs_valid; ir = if4.ins_ready; end
        endcase
        exp_ov = (q.size() > 0);
        exp_ir = rs && (q.size() < cap);
        check_eq("outs_valid", {31'd0, ov}, {31'd0, exp_ov});
        check_eq("ins_ready", {31'd0, ir}, {31'd0, exp_ir});
        if (exp_ov) begin
            check_eq("outs", o, q[0]);
        end
        last_push = v && exp_ir;
        pop       = exp_ov && r;
        if (pop) npop++;
        @(posedge clk);
        if (!rs) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (last_push) q.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic select(input int idx, input int slots);
        cur  = idx;
        cap  = slots;
        npop = 0;
        step(1'b0, 32'd0, 1'b0, 1'b0);   // reset pulse, model cleared
    endtask

    initial begin
        if4.ins = 32'd0; if4.ins_valid = 1'b0; if4.outs_ready = 1'b0;
        if3.ins = 32'd0; if3.ins_valid = 1'b0; if3.outs_ready = 1'b0;
        if1.ins = 32'd0; if1.ins_valid = 1'b0; if1.outs_ready = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Fill and drain
        select(0, 4);
        step(1'b1, 32'h3F80_0000, 1'b0, 1'b1);
        step(1'b1, 32'h4000_0000, 1'b0, 1'b1);
        step(1'b1, 32'h4040_0000, 1'b0, 1'b1);
        step(1'b1, 32'h4080_0000, 1'b0, 1'b1);
        step(1'b1, 32'h40A0_0000, 1'b0, 1'b1);
        check_eq("fifth_accepted", {31'd0, last_push}, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1, 1'b1);
        check_eq("drain_count", npop, 32'd4);
        step(1'b0, 32'd0, 1'b1, 1'b1);

        // Streaming 1..20
        select(0, 4);
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, i, 1'b1, 1'b1);
            check_eq("stream_accept", {31'd0, last_push}, 32'd1);
        end
        step(1'b0, 32'd0, 1'b1, 1'b1);
        check_eq("stream_count", npop, 32'd20);
        step(1'b0, 32'd0, 1'b1, 1'b1);

        // Backpressure stability
        select(0, 4);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 32'd0, 1'b0, 1'b1);
        check_eq("bp_no_pop", npop, 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        check_eq("bp_once", npop, 32'd1);

        // Reset mid-operation
        select(0, 4);
        step(1'b1, 32'h1111_1111, 1'b0, 1'b1);
        step(1'b1, 32'h2222_2222, 1'b0, 1'b1);
        step(1'b1, 32'h3333_3333, 1'b0, 1'b0);
        check_eq("rst_push", {31'd0, last_push}, 32'd0);
        step(1'b1, 32'h4444_4444, 1'b1, 1'b1);
        step(1'b1, 32'h5555_5555, 1'b1, 1'b1);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        check_eq("rst_flow", npop, 32'd2);

        // Wrap-around with random concurrent push/pop, 3 slots
        select(1, 3);
        begin
            int sent = 0;
            int guard = 0;
            while (sent < 1000 && guard < 20000) begin
                step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b1);
                if (last_push) sent++;
                guard++;
            end
            check_eq("wrap_sent", sent, 32'd1000);
            for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1, 1'b1);
            check_eq("wrap_count", npop, 32'd1000);
        end

        // Single slot
        select(2, 1);
        for (int i = 0; i < 20; i++) step(1'b1, 32'hA000_0000 + i, 1'b1, 1'b1);
        check_eq("single_rate", npop, 32'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_break_dv.md
# fifo_break_dv

Data-carrying elastic FIFO placed directly downstream of the floating-point arithmetic units such as `mulf`. It absorbs results when the consumer stalls, so the unit's pipeline-enable does not stop on every downstream bubble. It also cuts the combinational valid and data paths between the unit and its consumer. Storage is a circular buffer of `NUM_SLOTS` entries, each `DATA_TYPE` bits wide. The block has a registered output side and no input-to-output bypass.

## Interface
- `DATA_TYPE`, default 32: width of the data word; any value ≥ 1.
- `NUM_SLOTS`, default 4: number of storage entries; any value ≥ 1, not required to be a power of two.

Ports:
- `clk` input 1: single clock, rising-edge.
- `rst` input 1: reset, synchronous, active-low. It is sampled on the `clk` rising edge; `rst`=0 resets the block.
- `ins` input `DATA_TYPE`: incoming data, for example `mulf.result`.
- `ins_valid` input 1: upstream valid.
- `ins_ready` output 1: the FIFO can accept a word this cycle.
- `outs` output `DATA_TYPE`: head-of-queue data.
- `outs_valid` output 1: head-of-queue data is valid.
- `outs_ready` input 1: downstream ready.

## Operation
State:
- `mem[NUM_SLOTS]`
- `head` and `tail`, each 0..NUM_SLOTS-1
- `full` flag

`empty` is defined as `(head == tail) & !full`.

Combinational outputs:
- `outs` = `mem[head]`. The value is don't-care while `outs_valid`=0.
- `outs_valid` = `!empty`. This is a function of registered state only.
- `ins_ready` = `!full & rst`. It depends only on registered state and reset, never on `outs_ready` or `ins_valid`.

Events:
- push = `ins_valid & ins_ready`
- pop = `outs_valid & outs_ready`

On each rising edge with `rst`=1:
- If push: `mem[tail]` ← `ins`, and `tail` ← `tail`+1, wrapping from `NUM_SLOTS`-1 to 0.
- If pop: `head` ← `head`+1, with the same wrap rule.
- `full` ← 1 when push & !pop and the next `tail` equals `head`.
- `full` ← 0 when pop & !push.
- Otherwise `full` holds.

Simultaneous push and pop:
- Both pointers advance and occupancy is unchanged.
- This is legal when empty? No: pop requires `outs_valid`, so it never happens when empty.
- When full, push is blocked because `ins_ready`=0, so a full FIFO with `outs_ready`=1 only pops. There is no pass-through when full.

Ordering is strictly FIFO. No word is dropped or duplicated.

Reset (`rst`=0 at an edge):
- `head` ← 0, `tail` ← 0, `full` ← 0.
- `mem` contents are not reset.
- A reset in mid-operation discards all stored words.
- While `rst`=0, `ins_ready`=0, so no push is counted during reset.

## Timing
- Reset values, in the cycle after a reset edge: `outs_valid`=0, `ins_ready` equals the current `rst` level (1 once `rst` is released). `outs` is undefined.
- Latency: a word pushed at edge N appears on `outs` with `outs_valid`=1 in the cycle after edge N. Minimum ins-to-outs latency is 1 cycle, with no combinational path.
- Throughput:
  - 1 word/cycle when `NUM_SLOTS` ≥ 2 and the consumer is always ready.
  - For `NUM_SLOTS`=1 it is 1 word per 2 cycles, because a full slot blocks push until the pop edge.
- Handshake stability:
  - While `outs_valid`=1 and `outs_ready`=0, `outs` and `outs_valid` hold constant.
  - `ins_ready` falls only on the edge that makes the FIFO full.
- Upstream may drop `ins_valid` at any time; the block imposes no requirement on it.

## Test plan
- **Fill and drain:** `NUM_SLOTS`=4, `outs_ready`=0, push 0x3F800000, 0x40000000, 0x40400000, 0x40800000 on consecutive cycles.
  - `ins_ready`=0 after the 4th edge.
  - A 5th offered word, 0x40A00000, is not accepted.
  - Then set `outs_ready`=1: the four words emerge in order on 4 consecutive cycles, and `outs_valid`=0 afterwards.
- **Streaming:** `outs_ready`=1 constantly, push 1..20 every cycle.
  - Each word appears exactly 1 cycle after its push.
  - `ins_ready` stays 1 throughout, and the output is 1..20 in order.
- **Wrap-around with concurrent push/pop:** `NUM_SLOTS`=3, random `ins_valid`/`outs_ready` at 50%, 1000 words.
  - The scoreboard matches in order.
  - Occupancy never exceeds 3.
  - On a full cycle, `ins_ready`=0 even when `outs_ready`=1.
- **Backpressure stability:** with the head holding 0xDEADBEEF, drop `outs_ready` for 10 cycles.
  - `outs`=0xDEADBEEF and `outs_valid`=1 hold every cycle.
  - The word is consumed exactly once when `outs_ready` returns.
- **Reset mid-operation:** with 2 words stored, assert `rst`=0 for one edge while `ins_valid`=1.
  - Next cycle: `outs_valid`=0.
  - No word from before or during the reset ever appears.
  - After release, `ins_ready`=1 and new words flow normally.
- **Single slot:** `NUM_SLOTS`=1, `outs_ready`=1, `ins_valid`=1 constantly.
  - `ins_ready` alternates 1/0.
  - Output rate is 1 word per 2 cycles, in order.
